// File: rtl/axis_frame_len_stats.sv
// axis_frame_len_stats: observe-only AXI-Stream frame length monitor with a result queue and running statistics
module axis_frame_len_stats #(
    parameter int DATA_WIDTH  = 64,
    parameter bit KEEP_ENABLE = (DATA_WIDTH > 8),
    parameter int KEEP_WIDTH  = DATA_WIDTH / 8,
    parameter int LEN_WIDTH   = 16,
    parameter int CNT_WIDTH   = 32,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [KEEP_WIDTH-1:0] monitor_axis_tkeep,
    input  logic                  monitor_axis_tvalid,
    input  logic                  monitor_axis_tready,
    input  logic                  monitor_axis_tlast,
    input  logic                  monitor_axis_tuser,
    input  logic                  stat_clear,
    output logic [LEN_WIDTH-1:0]  m_len_tdata,
    output logic [1:0]            m_len_tuser,
    output logic                  m_len_tvalid,
    input  logic                  m_len_tready,
    output logic [CNT_WIDTH-1:0]  frame_count,
    output logic [CNT_WIDTH-1:0]  drop_count,
    output logic [LEN_WIDTH-1:0]  min_len,
    output logic [LEN_WIDTH-1:0]  max_len
);
    localparam int WW = $clog2(KEEP_WIDTH + 1);
    localparam int SW = LEN_WIDTH + WW + 1;
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [LEN_WIDTH-1:0] LEN_MAX = '1;

    typedef enum logic {IDLE, IN_FRAME} state_t;

    state_t                state, state_next;
    logic [LEN_WIDTH-1:0]  acc, acc_next, base_len, len_out;
    logic                  sat, sat_next, sat_out;
    logic [WW-1:0]         weight;
    logic [SW-1:0]         sum;
    logic                  beat, last_beat, push, pop, drop, empty, full;
    logic [AW:0]           wr_ptr, rd_ptr;
    logic [LEN_WIDTH+1:0]  mem [FIFO_DEPTH];
    logic [LEN_WIDTH+1:0]  head;

    assign beat      = monitor_axis_tvalid & monitor_axis_tready;
    assign last_beat = beat & monitor_axis_tlast;

    always_comb begin
        weight = '0;
        for (int i = 0; i < KEEP_WIDTH; i++) weight = weight + WW'(monitor_axis_tkeep[i]);
        if (!KEEP_ENABLE) weight = WW'(1);
    end

    // The accumulator only carries a value while inside a frame; IDLE always starts from zero.
    always_comb begin
        state_next = state;
        acc_next   = acc;
        sat_next   = sat;
        base_len   = (state == IN_FRAME) ? acc : '0;
        sum        = SW'(base_len) + SW'(weight);
        len_out    = (sum > SW'(LEN_MAX)) ? LEN_MAX : sum[LEN_WIDTH-1:0];
        sat_out    = ((state == IN_FRAME) && sat) || (sum > SW'(LEN_MAX));
        if (beat) begin
            state_next = monitor_axis_tlast ? IDLE : IN_FRAME;
            acc_next   = monitor_axis_tlast ? '0 : len_out;
            sat_next   = !monitor_axis_tlast && sat_out;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            acc   <= '0;
            sat   <= 1'b0;
        end else begin
            state <= state_next;
            acc   <= acc_next;
            sat   <= sat_next;
        end
    end

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign pop   = !empty && m_len_tready;
    assign push  = last_beat && (!full || pop);
    assign drop  = last_beat && full && !pop;
    assign head  = mem[rd_ptr[AW-1:0]];

    assign m_len_tvalid = !empty;
    assign m_len_tdata  = empty ? '0 : head[LEN_WIDTH-1:0];
    assign m_len_tuser  = empty ? '0 : head[LEN_WIDTH+1:LEN_WIDTH];

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr[AW-1:0]] <= {sat_out, monitor_axis_tuser, len_out};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + (AW+1)'(1);
            if (pop) rd_ptr <= rd_ptr + (AW+1)'(1);
        end
    end

    // Clear wins over a concurrent frame end, so that frame is simply not counted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_count <= '0;
            drop_count  <= '0;
            min_len     <= '1;
            max_len     <= '0;
        end else if (stat_clear) begin
            frame_count <= '0;
            drop_count  <= '0;
            min_len     <= '1;
            max_len     <= '0;
        end else if (last_beat) begin
            if (frame_count != '1) frame_count <= frame_count + CNT_WIDTH'(1);
            if (drop && drop_count != '1) drop_count <= drop_count + CNT_WIDTH'(1);
            if (!monitor_axis_tuser) begin
                if (len_out < min_len) min_len <= len_out;
                if (len_out > max_len) max_len <= len_out;
            end
        end
    end
endmodule

// File: tb/tb_axis_frame_len_stats.sv
// tb_axis_frame_len_stats: randomized and directed checks of axis_frame_len_stats against a queue-based model
module tb_axis_frame_len_stats;
    logic clk = 0;
    logic rst_n = 0;
    always #5 clk = ~clk;

    logic [7:0]  keep;
    logic        tvalid, mon_ready, tlast, tuser, stat_clear, m_len_tready;
    logic [15:0] len_tdata, min_len, max_len;
    logic [1:0]  len_tuser;
    logic        len_tvalid;
    logic [31:0] frame_count, drop_count;
    logic [3:0]  len2_tdata, min2, max2;
    logic [1:0]  len2_tuser;
    logic        len2_tvalid;
    logic [31:0] fc2, dc2;

    axis_frame_len_stats dut (
        .clk(clk), .rst_n(rst_n), .monitor_axis_tkeep(keep), .monitor_axis_tvalid(tvalid),
        .monitor_axis_tready(mon_ready), .monitor_axis_tlast(tlast), .monitor_axis_tuser(tuser),
        .stat_clear(stat_clear), .m_len_tdata(len_tdata), .m_len_tuser(len_tuser),
        .m_len_tvalid(len_tvalid), .m_len_tready(m_len_tready), .frame_count(frame_count),
        .drop_count(drop_count), .min_len(min_len), .max_len(max_len)
    );

    axis_frame_len_stats #(.LEN_WIDTH(4)) dut_narrow (
        .clk(clk), .rst_n(rst_n), .monitor_axis_tkeep(keep), .monitor_axis_tvalid(tvalid),
        .monitor_axis_tready(mon_ready), .monitor_axis_tlast(tlast), .monitor_axis_tuser(tuser),
        .stat_clear(stat_clear), .m_len_tdata(len2_tdata), .m_len_tuser(len2_tuser),
        .m_len_tvalid(len2_tvalid), .m_len_tready(m_len_tready), .frame_count(fc2),
        .drop_count(dc2), .min_len(min2), .max_len(max2)
    );

    int          passed = 0, total = 0;
    int          acc;
    logic [17:0] q[$];
    int          m_frames, m_drops;
    logic [15:0] m_min, m_max;

    task automatic model_reset();
        acc = 0;
        q.delete();
        m_frames = 0;
        m_drops = 0;
        m_min = '1;
        m_max = '0;
    endtask

    // One clock cycle: drive at the falling edge, advance the model at the rising edge.
    task automatic step(input logic [7:0] k, input logic v, mr, l, u, r, c);
        logic [17:0] e;
        bit full, pop;
        keep = k; tvalid = v; mon_ready = mr; tlast = l; tuser = u; m_len_tready = r; stat_clear = c;
        @(posedge clk);
        full = (q.size() >= 4);
        pop = (q.size() != 0) && r;
        if (pop) void'(q.pop_front());
        if (v && mr) begin
            acc += $countones(k);
            if (l) begin
                e = {acc > 65535, u, (acc > 65535) ? 16'hffff : 16'(acc)};
                if (!full || pop) q.push_back(e);
                if (!c) begin
                    m_frames++;
                    if (full && !pop) m_drops++;
                    if (!u && e[15:0] < m_min) m_min = e[15:0];
                    if (!u && e[15:0] > m_max) m_max = e[15:0];
                end
                acc = 0;
            end
        end
        if (c) begin
            m_frames = 0; m_drops = 0; m_min = '1; m_max = '0;
        end
        @(negedge clk);
    endtask

    task automatic hold_reset();
        keep = 0; tvalid = 0; mon_ready = 0; tlast = 0; tuser = 0; stat_clear = 0; m_len_tready = 0;
        rst_n = 0;
        model_reset();
        #1;
    endtask

    task automatic release_reset();
        @(negedge clk);
        rst_n = 1;
        @(negedge clk);
    endtask

    task automatic test_drain(input string name, output int n);
        n = 0;
        for (int i = 0; i < 8 && q.size() != 0; i++) begin
            total++; if (len_tvalid !== 1'b1) $display("FAIL %s_tvalid got %0b want 1", name, len_tvalid); else passed++;
            total++; if ({len_tuser, len_tdata} !== q[0]) $display("FAIL %s_entry got %h want %h", name, {len_tuser, len_tdata}, q[0]); else passed++;
            step(0, 0, 0, 0, 0, 1, 0);
            n++;
        end
        total++; if (len_tvalid !== 1'b0) $display("FAIL %s_empty got tvalid %0b want 0", name, len_tvalid); else passed++;
    endtask

    task automatic test_reset();
        hold_reset();
        @(negedge clk);
        total++; if (len_tvalid !== 1'b0) $display("FAIL reset_tvalid got %0b want 0", len_tvalid); else passed++;
        total++; if (len_tdata !== 16'h0) $display("FAIL reset_tdata got %h want 0", len_tdata); else passed++;
        total++; if (len_tuser !== 2'b00) $display("FAIL reset_tuser got %b want 00", len_tuser); else passed++;
        total++; if (frame_count !== 32'h0) $display("FAIL reset_frames got %0d want 0", frame_count); else passed++;
        total++; if (drop_count !== 32'h0) $display("FAIL reset_drops got %0d want 0", drop_count); else passed++;
        total++; if (min_len !== 16'hffff) $display("FAIL reset_min got %h want ffff", min_len); else passed++;
        total++; if (max_len !== 16'h0) $display("FAIL reset_max got %h want 0", max_len); else passed++;
        total++; if (min2 !== 4'hf) $display("FAIL reset_min_narrow got %h want f", min2); else passed++;
        release_reset();
    endtask

    task automatic test_basic();
        int n;
        step(8'hff, 1, 1, 0, 0, 0, 0);
        step(8'hff, 1, 1, 0, 0, 0, 0);
        step(8'h0f, 1, 1, 1, 0, 0, 0);
        total++; if (len_tvalid !== 1'b1) $display("FAIL basic_tvalid got %0b want 1", len_tvalid); else passed++;
        total++; if (len_tdata !== 16'd20) $display("FAIL basic_len got %0d want 20", len_tdata); else passed++;
        total++; if (len_tuser !== 2'b00) $display("FAIL basic_tuser got %b want 00", len_tuser); else passed++;
        total++; if (frame_count !== 32'd1) $display("FAIL basic_frames got %0d want 1", frame_count); else passed++;
        total++; if (min_len !== 16'd20 || max_len !== 16'd20) $display("FAIL basic_minmax got %0d/%0d want 20/20", min_len, max_len); else passed++;
        test_drain("basic", n);
    endtask

    task automatic test_saturation();
        int n;
        hold_reset();
        release_reset();
        for (int i = 0; i < 5; i++) step(8'hff, 1, 1, i == 4, 0, 0, 0);
        total++; if (len2_tdata !== 4'd15) $display("FAIL sat_len got %0d want 15", len2_tdata); else passed++;
        total++; if (len2_tuser !== 2'b10) $display("FAIL sat_tuser got %b want 10", len2_tuser); else passed++;
        total++; if (len_tdata !== 16'd40 || len_tuser !== 2'b00) $display("FAIL sat_wide got %0d/%b want 40/00", len_tdata, len_tuser); else passed++;
        test_drain("sat", n);
    endtask

    task automatic test_fifo_full();
        int n;
        hold_reset();
        release_reset();
        for (int i = 0; i < 6; i++) step(8'($urandom_range(0, 255)), 1, 1, 1, 0, 0, 0);
        total++; if (drop_count !== 32'd2) $display("FAIL full_drops got %0d want 2", drop_count); else passed++;
        total++; if (frame_count !== 32'd6) $display("FAIL full_frames got %0d want 6", frame_count); else passed++;
        step(8'h3c, 1, 1, 1, 0, 1, 0);
        total++; if (drop_count !== 32'd2) $display("FAIL full_pushpop_drops got %0d want 2", drop_count); else passed++;
        total++; if (frame_count !== 32'd7) $display("FAIL full_pushpop_frames got %0d want 7", frame_count); else passed++;
        test_drain("full", n);
        total++; if (n !== 4) $display("FAIL full_depth got %0d entries want 4", n); else passed++;
    endtask

    task automatic test_bad_frame();
        int n;
        step(0, 0, 0, 0, 0, 0, 1);
        total++; if (frame_count !== 32'd0 || drop_count !== 32'd0) $display("FAIL clear_counts got %0d/%0d want 0/0", frame_count, drop_count); else passed++;
        step(8'hff, 1, 1, 0, 0, 0, 0);
        step(8'h03, 1, 1, 1, 0, 0, 0);
        step(8'h07, 1, 1, 1, 1, 0, 0);
        total++; if (min_len !== 16'd10 || max_len !== 16'd10) $display("FAIL bad_minmax got %0d/%0d want 10/10", min_len, max_len); else passed++;
        total++; if (frame_count !== 32'd2) $display("FAIL bad_frames got %0d want 2", frame_count); else passed++;
        test_drain("bad", n);
    endtask

    task automatic test_clear_priority();
        int n;
        step(8'hff, 1, 1, 1, 0, 0, 1);
        total++; if (frame_count !== 32'd0) $display("FAIL clrpri_frames got %0d want 0", frame_count); else passed++;
        total++; if (min_len !== 16'hffff) $display("FAIL clrpri_min got %h want ffff", min_len); else passed++;
        total++; if (len_tvalid !== 1'b1 || len_tdata !== 16'd8) $display("FAIL clrpri_fifo got %0b/%0d want 1/8", len_tvalid, len_tdata); else passed++;
        test_drain("clrpri", n);
    endtask

    task automatic test_midframe_reset();
        int n;
        step(8'hff, 1, 1, 0, 0, 0, 0);
        step(8'hff, 1, 1, 0, 0, 0, 0);
        hold_reset();
        total++; if (len_tvalid !== 1'b0 || len_tdata !== 16'h0) $display("FAIL midrst_out got %0b/%h want 0/0", len_tvalid, len_tdata); else passed++;
        total++; if (frame_count !== 32'h0 || min_len !== 16'hffff) $display("FAIL midrst_stats got %0d/%h want 0/ffff", frame_count, min_len); else passed++;
        release_reset();
        step(8'hff, 1, 1, 1, 0, 0, 0);
        total++; if (len_tdata !== 16'd8) $display("FAIL midrst_len got %0d want 8", len_tdata); else passed++;
        total++; if (frame_count !== 32'd1) $display("FAIL midrst_frames got %0d want 1", frame_count); else passed++;
        test_drain("midrst", n);
        total++; if (n !== 1) $display("FAIL midrst_count got %0d want 1", n); else passed++;
    endtask

    task automatic test_random();
        int n;
        hold_reset();
        release_reset();
        for (int i = 0; i < 400; i++) begin
            total++; if (len_tvalid !== (q.size() != 0)) $display("FAIL rand_tvalid cycle %0d got %0b want %0b", i, len_tvalid, q.size() != 0); else passed++;
            if (q.size() != 0) begin
                total++; if ({len_tuser, len_tdata} !== q[0]) $display("FAIL rand_head cycle %0d got %h want %h", i, {len_tuser, len_tdata}, q[0]); else passed++;
            end
            step(8'($urandom_range(0, 255)), $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0,
                 $urandom_range(0, 3) == 0, $urandom_range(0, 5) == 0, $urandom_range(0, 2) == 0,
                 $urandom_range(0, 59) == 0);
        end
        total++; if (frame_count !== 32'(m_frames)) $display("FAIL rand_frames got %0d want %0d", frame_count, m_frames); else passed++;
        total++; if (drop_count !== 32'(m_drops)) $display("FAIL rand_drops got %0d want %0d", drop_count, m_drops); else passed++;
        total++; if (min_len !== m_min) $display("FAIL rand_min got %0d want %0d", min_len, m_min); else passed++;
        total++; if (max_len !== m_max) $display("FAIL rand_max got %0d want %0d", max_len, m_max); else passed++;
        test_drain("rand", n);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_saturation();
        test_fifo_full();
        test_bad_frame();
        test_clear_priority();
        test_midframe_reset();
        test_random();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
